// File: rtl/basys2_disp_pkg.sv
// Shared constants for the Basys2 seven-segment display path.
package basys2_disp_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  // Active-low {g,f,e,d,c,b,a} patterns, index = hex nibble (entry 15 listed first)
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // Active-low anode pattern that lights only the given digit (0 = rightmost)
  function automatic logic [3:0] digit_to_an(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/sevenseg_scan_driver_hex_to_7seg.sv
// Hex nibble to active-low seven-segment pattern.
module hex_to_7seg
  import basys2_disp_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed 4-digit common-anode driver with per-frame snapshot,
// inter-digit dead time, per-digit blanking and decimal points.
module sevenseg_scan_driver
  import basys2_disp_pkg::*;
#(
  parameter int PRESCALE_BITS = 16,
  parameter int BLANK_CYCLES  = 64
) (
  input  logic        clk,
  input  logic        clear,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic [3:0]  blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic        frame_start
);

  localparam logic [PRESCALE_BITS-1:0] BLANK_LIM = PRESCALE_BITS'(BLANK_CYCLES);

  logic [PRESCALE_BITS-1:0] pre_q, pre_d;
  logic [1:0]               idx_q, idx_d;
  logic [15:0]              shadow_value_q;
  logic [3:0]               shadow_dp_q;
  logic [3:0]               shadow_blank_q;
  logic [3:0]               an_q, an_d;
  logic [6:0]               seg_q, seg_d;
  logic                     dp_n_q, dp_n_d;
  logic                     frame_start_q;
  logic                     snap;
  logic                     lit;
  logic [3:0]               nibble;
  logic [6:0]               seg_sel;

  assign nibble = shadow_value_q[{idx_q, 2'b00} +: 4];

  hex_to_7seg u_hex (
    .nibble_i (nibble),
    .seg_o    (seg_sel)
  );

  // Next prescaler/digit state and the output pattern for the current slot phase
  always_comb begin
    pre_d  = pre_q + PRESCALE_BITS'(1);
    idx_d  = (&pre_q) ? idx_q + 2'd1 : idx_q;
    snap   = (idx_q == 2'd0) && (pre_q == '0);
    lit    = (pre_q >= BLANK_LIM) && !shadow_blank_q[idx_q];
    an_d   = lit ? digit_to_an(idx_q) : AN_OFF;
    seg_d  = lit ? seg_sel : SEG_OFF;
    dp_n_d = lit ? ~shadow_dp_q[idx_q] : 1'b1;
  end

  // Scan state, frame snapshot and registered display drives; clear darkens at once
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      pre_q          <= '0;
      idx_q          <= 2'd0;
      shadow_value_q <= 16'h0000;
      shadow_dp_q    <= 4'h0;
      shadow_blank_q <= 4'h0;
      an_q           <= AN_OFF;
      seg_q          <= SEG_OFF;
      dp_n_q         <= 1'b1;
      frame_start_q  <= 1'b0;
    end else begin
      pre_q         <= pre_d;
      idx_q         <= idx_d;
      frame_start_q <= snap;
      if (snap) begin
        shadow_value_q <= value;
        shadow_dp_q    <= dp;
        shadow_blank_q <= blank;
      end
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_n_q <= dp_n_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp_n        = dp_n_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Self-checking bench for sevenseg_scan_driver with a short prescaler.
module tb_sevenseg_scan_driver;

  localparam int PB    = 4;
  localparam int BC    = 2;
  localparam int SLOT  = 1 << PB;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        clear = 1'b1;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dp = 4'h0;
  logic [3:0]  blank = 4'h0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  sevenseg_scan_driver #(.PRESCALE_BITS(PB), .BLANK_CYCLES(BC)) dut (
    .clk         (clk),
    .clear       (clear),
    .value       (value),
    .dp          (dp),
    .blank       (blank),
    .an          (an),
    .seg         (seg),
    .dp_n        (dp_n),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Reference model state: edges since clear released and the frame's captured inputs
  logic [6:0]  hex_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  int          n;
  logic [15:0] m_val;
  logic [3:0]  m_dp, m_blank;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dpn, exp_fs;
  int          k_in_frame;

  task automatic model_reset();
    n = 0;
    m_val = 16'h0000;
    m_dp = 4'h0;
    m_blank = 4'h0;
  endtask

  // Advance one clock edge and compute what the display should show afterwards
  task automatic tick();
    logic [15:0] v_in;
    logic [3:0]  dp_in, bl_in;
    int c, p, i;
    v_in = value;
    dp_in = dp;
    bl_in = blank;
    @(posedge clk);
    #1;
    c = n;
    n = n + 1;
    p = c % SLOT;
    i = (c / SLOT) % 4;
    k_in_frame = c % FRAME;
    if (p < BC || m_blank[i]) begin
      exp_an = 4'b1111;
      exp_seg = 7'b1111111;
      exp_dpn = 1'b1;
    end else begin
      exp_an = 4'b1111;
      exp_an[i] = 1'b0;
      exp_seg = hex_tab[m_val[4*i +: 4]];
      exp_dpn = ~m_dp[i];
    end
    exp_fs = (c % FRAME == 0);
    if (c % FRAME == 0) begin
      m_val = v_in;
      m_dp = dp_in;
      m_blank = bl_in;
    end
  endtask

  task automatic sync_frame();
    while (n % FRAME != 0) tick();
  endtask

  task automatic test_reset();
    checks++;
    if ({an, seg, dp_n, frame_start} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_initial: got an=%b seg=%b dp_n=%b fs=%b, want 1111 1111111 1 0",
               an, seg, dp_n, frame_start);
    end
    @(negedge clk);
    value = 16'h1234;
    clear = 1'b0;
    model_reset();
    repeat (FRAME + 6) tick();
    checks++;
    if (an !== exp_an || an === 4'b1111) begin
      errors++;
      $display("FAIL pre_clear_drive: got an=%b, want %b (lit)", an, exp_an);
    end
    #2;
    clear = 1'b1;
    #1;
    checks++;
    if ({an, seg, dp_n, frame_start} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL async_clear: got an=%b seg=%b dp_n=%b fs=%b, want 1111 1111111 1 0",
               an, seg, dp_n, frame_start);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    value = 16'h0000;
    clear = 1'b0;
    model_reset();
    tick();
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL first_edge_fs: got %b, want 1", frame_start);
    end
    for (int e = 0; e < FRAME - 1; e++) begin
      tick();
      checks++;
      if (frame_start !== 1'b0) begin
        errors++;
        $display("FAIL fs_quiet edge %0d: got %b, want 0", e + 2, frame_start);
      end
    end
  endtask

  task automatic test_digit_scan();
    value = 16'h0005;
    dp = 4'h0;
    blank = 4'h0;
    sync_frame();
    for (int k = 0; k < 2 * SLOT; k++) begin
      logic [3:0] want_an;
      logic [6:0] want_seg;
      tick();
      if (k % SLOT < BC) begin
        want_an = 4'b1111;
        want_seg = 7'b1111111;
      end else if (k < SLOT) begin
        want_an = 4'b1110;
        want_seg = 7'b0010010;
      end else begin
        want_an = 4'b1101;
        want_seg = 7'b1000000;
      end
      checks++;
      if (an !== want_an || seg !== want_seg) begin
        errors++;
        $display("FAIL digit_scan k=%0d: got an=%b seg=%b, want an=%b seg=%b",
                 k, an, seg, want_an, want_seg);
      end
    end
  endtask

  task automatic test_hex_dp();
    logic [6:0] want [4];
    want = '{7'b0010000, 7'b1000110, 7'b0000011, 7'b0001000};
    value = 16'hABC9;
    dp = 4'b0100;
    sync_frame();
    for (int k = 0; k < FRAME; k++) begin
      tick();
      checks++;
      if ((dp_n === 1'b0) !== (an === 4'b1011)) begin
        errors++;
        $display("FAIL dp_select k=%0d: got an=%b dp_n=%b, want dp_n low only with an=1011",
                 k, an, dp_n);
      end
      if (k % SLOT >= BC) begin
        checks++;
        if (seg !== want[k / SLOT] || an !== exp_an) begin
          errors++;
          $display("FAIL hex_digit k=%0d: got seg=%b an=%b, want seg=%b an=%b",
                   k, seg, an, want[k / SLOT], exp_an);
        end
      end
    end
    dp = 4'h0;
  endtask

  task automatic test_snapshot();
    value = 16'h0001;
    sync_frame();
    for (int k = 0; k < FRAME; k++) begin
      tick();
      if (k == 2 * SLOT + 8) value = 16'h0007;
      if (k % SLOT >= BC) begin
        checks++;
        if (seg !== (k < SLOT ? 7'b1111001 : 7'b1000000)) begin
          errors++;
          $display("FAIL snapshot_hold k=%0d: got seg=%b, want %b", k, seg,
                   (k < SLOT ? 7'b1111001 : 7'b1000000));
        end
      end
    end
    for (int k = 0; k < SLOT; k++) begin
      tick();
      if (k == 0) begin
        checks++;
        if (frame_start !== 1'b1) begin
          errors++;
          $display("FAIL snapshot_fs: got %b, want 1", frame_start);
        end
      end
      if (k >= BC) begin
        checks++;
        if (seg !== 7'b1111000 || an !== 4'b1110) begin
          errors++;
          $display("FAIL snapshot_new k=%0d: got seg=%b an=%b, want 1111000 1110", k, seg, an);
        end
      end
    end
  endtask

  task automatic test_blank();
    value = 16'h0003;
    blank = 4'b1110;
    sync_frame();
    for (int k = 0; k < FRAME; k++) begin
      logic [3:0] want_an;
      tick();
      want_an = (k < SLOT && k >= BC) ? 4'b1110 : 4'b1111;
      checks++;
      if (an !== want_an || (want_an == 4'b1110 && seg !== 7'b0110000)) begin
        errors++;
        $display("FAIL blank k=%0d: got an=%b seg=%b, want an=%b seg=0110000 when lit",
                 k, an, seg, want_an);
      end
    end
    blank = 4'h0;
  endtask

  task automatic test_random();
    logic [3:0] prev_an;
    logic [6:0] prev_seg;
    int last_fs;
    prev_an = 4'b1111;
    prev_seg = 7'b1111111;
    last_fs = -1;
    for (int f = 0; f < 10; f++) begin
      value = 16'($urandom);
      dp = 4'($urandom_range(0, 15));
      blank = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      sync_frame();
      for (int k = 0; k < FRAME; k++) begin
        tick();
        if ($urandom_range(0, 15) == 0) value = 16'($urandom);
        checks++;
        if ({an, seg, dp_n, frame_start} !== {exp_an, exp_seg, exp_dpn, exp_fs}) begin
          errors++;
          $display("FAIL random_model f=%0d k=%0d: got an=%b seg=%b dp_n=%b fs=%b, want %b %b %b %b",
                   f, k, an, seg, dp_n, frame_start, exp_an, exp_seg, exp_dpn, exp_fs);
        end
        checks++;
        if (!$onehot0(~an)) begin
          errors++;
          $display("FAIL one_anode f=%0d k=%0d: got an=%b, want at most one low", f, k, an);
        end
        checks++;
        if (prev_an != 4'b1111 && an != 4'b1111 && seg !== prev_seg) begin
          errors++;
          $display("FAIL seg_stable f=%0d k=%0d: got seg %b -> %b while lit, want unchanged",
                   f, k, prev_seg, seg);
        end
        if (frame_start === 1'b1) begin
          if (last_fs >= 0) begin
            checks++;
            if (n - last_fs != FRAME) begin
              errors++;
              $display("FAIL fs_period: got %0d, want %0d", n - last_fs, FRAME);
            end
          end
          last_fs = n;
        end
        prev_an = an;
        prev_seg = seg;
      end
    end
  endtask

  initial begin
    model_reset();
    exp_an = 4'b1111;
    exp_seg = 7'b1111111;
    exp_dpn = 1'b1;
    exp_fs = 1'b0;
    k_in_frame = 0;
    #12;
    test_reset();
    test_digit_scan();
    test_hex_dp();
    test_snapshot();
    test_blank();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
